// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction path: heading codes, reversal test
// and the step-handshake state encoding.
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP        = 2'b00;
   localparam dir_t DIR_RIGHT     = 2'b01;
   localparam dir_t DIR_DOWN      = 2'b10;
   localparam dir_t DIR_LEFT      = 2'b11;
   localparam dir_t RESET_HEADING = DIR_RIGHT;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   // Opposite headings differ only in the upper code bit.
   function automatic logic is_reversal(input dir_t a, input dir_t b);
      return (a ^ b) == 2'b10;
   endfunction

endpackage

// File: rtl/direction_arbiter_if.sv
// Controller-facing bundle of the direction arbiter: button inputs, step
// handshake and queue status.
interface direction_arbiter_if #(
   parameter int QUEUE_DEPTH = 2
);
   localparam int PEND_W = $clog2(QUEUE_DEPTH) + 1;

   logic              clear;
   logic [3:0]        direction_in;
   logic              step_req;
   logic              step_ack;
   logic [1:0]        heading;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   modport master (
      output clear, direction_in, step_req,
      input  step_ack, heading, pending, overflow
   );

   modport slave (
      input  clear, direction_in, step_req,
      output step_ack, heading, pending, overflow
   );
endinterface

// File: rtl/dir_debounce.sv
// One-bit button filter: the output level follows the input only after
// DEB_CYCLES consecutive samples that disagree with it.
module dir_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clka,
   input  logic restart_n,
   input  logic clear,
   input  logic din,
   output logic level
);
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (din == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
         level_d = din;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else if (clear) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
endmodule

// File: rtl/direction_arbiter.sv
// Button presses -> round-robin pick -> legality filter -> small turn queue,
// drained one heading per step request. Optional input filter: DIR_DEBOUNCE_EN.
module direction_arbiter
   import snake_pkg::*;
#(
   parameter int QUEUE_DEPTH = 2,
   parameter int DEB_CYCLES  = 4
) (
   input logic               clka,
   input logic               restart_n,
   direction_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("QUEUE_DEPTH must be a power of two >= 2");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("DEB_CYCLES must be >= 1");
   end

   logic [3:0] samp_q, prev_q, level, rise;

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         samp_q <= '0;
         prev_q <= '0;
      end else if (bus.clear) begin
         samp_q <= '0;
         prev_q <= '0;
      end else begin
         samp_q <= bus.direction_in;
         prev_q <= level;
      end
   end

`ifdef DIR_DEBOUNCE_EN
   for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      dir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clka      (clka),
         .restart_n (restart_n),
         .clear     (bus.clear),
         .din       (samp_q[gi]),
         .level     (level[gi])
      );
   end
`else
   assign level = samp_q;
`endif

   assign rise = level & ~prev_q;

   dir_t             rr_ptr_q, heading_q, grant_idx, cand, tail;
   logic             grant_vld, legal, full, push, pop, drop;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] pending_q;
   logic             overflow_q;
   dir_t             q_mem [QUEUE_DEPTH];
   state_t           state_q, state_d;

   // Search order rr_ptr+1, +2, +3, then rr_ptr itself.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int k = 1; k <= 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!grant_vld && rise[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign tail  = (pending_q != '0) ? q_mem[wr_ptr_q - PTR_W'(1)] : heading_q;
   assign legal = grant_vld && (grant_idx != tail) && !is_reversal(grant_idx, tail);
   assign full  = (pending_q == CNT_W'(QUEUE_DEPTH));
   assign push  = legal && !full;
   assign drop  = legal && full;
   assign pop   = (state_q == ST_IDLE) && (state_d == ST_ACK) && (pending_q != '0);

   always_ff @(posedge clka) begin
      if (push && !bus.clear) begin
         q_mem[wr_ptr_q] <= grant_idx;
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         rr_ptr_q   <= DIR_UP;
         heading_q  <= RESET_HEADING;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else if (bus.clear) begin
         rr_ptr_q   <= DIR_UP;
         heading_q  <= RESET_HEADING;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (grant_vld) rr_ptr_q <= grant_idx;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            heading_q <= q_mem[rd_ptr_q];
         end
         if (push && !pop) pending_q <= pending_q + CNT_W'(1);
         else if (pop && !push) pending_q <= pending_q - CNT_W'(1);
         if (drop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n)     state_q <= ST_IDLE;
      else if (bus.clear) state_q <= ST_IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.step_req) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.step_ack = (state_q == ST_ACK);
   end

   assign bus.heading  = heading_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_direction_arbiter.sv
// Directed bench for direction_arbiter: queue-level reference model compared
// every cycle, plus literal checkpoints for each scenario.
module tb_direction_arbiter;
   localparam int QD  = 2;
   localparam int DEB = 4;
`ifdef DIR_DEBOUNCE_EN
   localparam int LAT  = DEB + 2;
   localparam int HOLD = DEB + 1;
   localparam int REL  = DEB + 3;
`else
   localparam int LAT  = 2;
   localparam int HOLD = 1;
   localparam int REL  = 1;
`endif

   logic clka = 1'b0;
   logic restart_n = 1'b0;

   direction_arbiter_if #(.QUEUE_DEPTH(QD)) bus ();

   direction_arbiter #(.QUEUE_DEPTH(QD), .DEB_CYCLES(DEB)) dut (
      .clka      (clka),
      .restart_n (restart_n),
      .bus       (bus)
   );

   always #5 clka = ~clka;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference model: heading, turn queue, sticky flag, ack flag, filtered button history.
   int         m_hd, m_rr;
   bit         m_ack, m_ovf;
   int         mq[$];
   logic [3:0] m_lv1, m_lv2, m_samp;
   int         m_run[4];

   task automatic model_reset();
      m_hd = 1; m_rr = 0; m_ack = 0; m_ovf = 0;
      mq.delete();
      m_lv1 = '0; m_lv2 = '0; m_samp = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
   endtask

   task automatic model_step();
      logic [3:0] rise, nl;
      int  cand, tail;
      bit  got, legal, enter_ack;
      if (!restart_n || bus.clear) begin
         model_reset();
      end else begin
         rise = m_lv1 & ~m_lv2;
         got = 0; cand = 0;
         for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (!got && rise[idx]) begin got = 1; cand = idx; end
         end
         tail  = (mq.size() > 0) ? mq[$] : m_hd;
         legal = got && (cand != tail) && ((cand ^ tail) != 2);
         enter_ack = !m_ack && bus.step_req;
         if (got) m_rr = cand;
         if (legal && mq.size() == QD) m_ovf = 1;
         if (legal && mq.size() < QD) begin
            if (enter_ack && mq.size() > 0) m_hd = mq.pop_front();
            mq.push_back(cand);
         end else if (enter_ack && mq.size() > 0) begin
            m_hd = mq.pop_front();
         end
         m_ack = enter_ack;
         nl = m_lv1;
`ifdef DIR_DEBOUNCE_EN
         for (int b = 0; b < 4; b++) begin
            if (m_samp[b] == m_lv1[b]) m_run[b] = 0;
            else begin
               m_run[b]++;
               if (m_run[b] == DEB) begin nl[b] = m_samp[b]; m_run[b] = 0; end
            end
         end
         m_samp = bus.direction_in;
`else
         nl = bus.direction_in;
`endif
         m_lv2 = m_lv1;
         m_lv1 = nl;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clka or negedge restart_n);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clka);
         if (restart_n) begin
            chk("cyc_ack",      bus.step_ack, m_ack);
            chk("cyc_heading",  bus.heading,  m_hd);
            chk("cyc_pending",  bus.pending,  mq.size());
            chk("cyc_overflow", bus.overflow, m_ovf);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Press a button pattern, optionally checking the exact press-to-pending latency.
   task automatic press(input logic [3:0] mask, input int hold, input bit lat_chk, input int exp_after);
      int pre;
      @(negedge clka);
      pre = int'(bus.pending);
      bus.direction_in = mask;
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clka);
         if (i == hold) bus.direction_in = 4'b0000;
         if (lat_chk && i == LAT - 1) chk("lat_before", bus.pending, pre);
         if (lat_chk && i == LAT)     chk("lat_after",  bus.pending, exp_after);
      end
      repeat (REL) @(negedge clka);
      $display("press mask=%b pending=%0d overflow=%0d heading=%0d", mask, bus.pending, bus.overflow, bus.heading);
   endtask

   task automatic step(output logic ack, output logic [1:0] hd, output logic [1:0] pend);
      @(negedge clka);
      bus.step_req = 1'b1;
      @(negedge clka);
      bus.step_req = 1'b0;
      ack = bus.step_ack; hd = bus.heading; pend = bus.pending;
      @(negedge clka);
      $display("step ack=%0d heading=%0d pending=%0d", ack, hd, pend);
   endtask

   logic       a;
   logic [1:0] h, p;

   initial begin
      bus.clear = 1'b0; bus.direction_in = 4'b0000; bus.step_req = 1'b0;
      repeat (3) @(negedge clka);
      restart_n = 1'b1;
      @(negedge clka);
      chk("rst_heading", bus.heading, 1);
      chk("rst_pending", bus.pending, 0);
      chk("rst_ack", bus.step_ack, 0);
      chk("rst_overflow", bus.overflow, 0);

      step(a, h, p);
      chk("t1_ack", a, 1); chk("t1_heading", h, 1);
      @(negedge clka);
      chk("t1_ack_once", bus.step_ack, 0);

      press(4'b0001, HOLD, 1'b1, 1);
      step(a, h, p);
      chk("t2_ack", a, 1); chk("t2_heading", h, 0); chk("t2_pending", p, 0);

      press(4'b0010, HOLD, 1'b0, 0);
      step(a, h, p);
      chk("t3_setup_heading", h, 1);
      press(4'b1000, HOLD, 1'b0, 0);
      chk("t3_reversal", bus.pending, 0);
      press(4'b0010, HOLD, 1'b0, 0);
      chk("t3_duplicate", bus.pending, 0);
      chk("t3_no_overflow", bus.overflow, 0);

      press(4'b0001, HOLD, 1'b0, 0);
      press(4'b0010, HOLD, 1'b0, 0);
      chk("t4_two_queued", bus.pending, 2);
      press(4'b0100, HOLD, 1'b0, 0);
      chk("t4_full_pending", bus.pending, 2);
      chk("t4_overflow", bus.overflow, 1);
      step(a, h, p); chk("t4_pop1", h, 0);
      step(a, h, p); chk("t4_pop2", h, 1); chk("t4_empty", p, 0);
      chk("t4_sticky", bus.overflow, 1);

      @(negedge clka); bus.clear = 1'b1;
      @(negedge clka); bus.clear = 1'b0;
      chk("clr_overflow", bus.overflow, 0);
      chk("clr_heading", bus.heading, 1);

      press(4'b0101, HOLD, 1'b0, 0);
      chk("t5_pending", bus.pending, 1);
      step(a, h, p); chk("t5_down_granted", h, 2);
      press(4'b1001, HOLD, 1'b0, 0);
      step(a, h, p); chk("t5_left_granted", h, 3);

      press(4'b0001, HOLD, 1'b0, 0);
      @(negedge clka);
      bus.direction_in = 4'b0010;
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clka);
         if (i == HOLD) bus.direction_in = 4'b0000;
         if (i == LAT - 1) bus.step_req = 1'b1;
         if (i == LAT) bus.step_req = 1'b0;
      end
      chk("t6_ack", bus.step_ack, 1);
      chk("t6_pending", bus.pending, 1);
      chk("t6_heading", bus.heading, 0);
      $display("push+pop heading=%0d pending=%0d", bus.heading, bus.pending);
      repeat (REL) @(negedge clka);
      step(a, h, p); chk("t6_next_heading", h, 1);

      press(4'b0001, HOLD, 1'b0, 0);
      press(4'b1000, HOLD, 1'b0, 0);
      press(4'b0010, HOLD, 1'b0, 0);
      chk("t7_rev_no_ovf", bus.overflow, 0);
      press(4'b0100, HOLD, 1'b0, 0);
      chk("t7_full", bus.pending, 2);
      chk("t7_ovf", bus.overflow, 1);
      @(negedge clka); bus.step_req = 1'b1;
      @(negedge clka); bus.step_req = 1'b0;
      chk("t7_in_ack", bus.step_ack, 1);
      bus.clear = 1'b1;
      @(negedge clka); bus.clear = 1'b0;
      chk("t7_heading", bus.heading, 1);
      chk("t7_pending", bus.pending, 0);
      chk("t7_ack", bus.step_ack, 0);
      chk("t7_overflow", bus.overflow, 0);

      press(4'b0001, HOLD, 1'b0, 0);
      @(negedge clka); bus.step_req = 1'b1;
      @(negedge clka); bus.step_req = 1'b0;
      chk("ar_in_ack", bus.step_ack, 1);
      #2 restart_n = 1'b0;
      #1;
      chk("ar_ack_drop", bus.step_ack, 0);
      chk("ar_pending", bus.pending, 0);
      chk("ar_heading", bus.heading, 1);
      @(negedge clka); restart_n = 1'b1;
      $display("async reset mid-ack heading=%0d pending=%0d", bus.heading, bus.pending);

`ifdef DIR_DEBOUNCE_EN
      @(negedge clka); bus.direction_in = 4'b0001;
      repeat (2) @(negedge clka);
      bus.direction_in = 4'b0000;
      repeat (12) @(negedge clka);
      chk("t8_glitch", bus.pending, 0);
      press(4'b0001, DEB + 2, 1'b1, 1);
`endif

      repeat (3) @(negedge clka);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
